// File: rtl/generic_pool_cfg_task_queue.sv
// Shadow register bank for pool/post-MAC/upsample/feature-map/buffer parameters.
// A commit snapshots the bank into a descriptor FIFO that the core drains with
// valid/ready, so host setup of the next task overlaps execution of the current one.
module generic_pool_cfg_task_queue #(
    parameter int unsigned REG_N      = 10,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          reg_wen,
    input  logic [ADDR_W-1:0]             reg_waddr,
    input  logic [31:0]                   reg_wdata,
    input  logic [3:0]                    reg_wstrb,
    input  logic                          reg_ren,
    input  logic [ADDR_W-1:0]             reg_raddr,
    output logic [31:0]                   reg_rdata,
    output logic                          reg_rvalid,
    output logic                          cfg_valid,
    input  logic                          cfg_ready,
    output logic [REG_N*32-1:0]           cfg_desc,
    input  logic                          task_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned DESC_W = REG_N * 32;
    localparam logic [ADDR_W-1:0] CMD_ADDR  = ADDR_W'(REG_N);
    localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(REG_N + 1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    logic [31:0]       shadow_q [REG_N];
    logic [31:0]       shadow_d [REG_N];
    logic [DESC_W-1:0] shadow_flat;
    logic [DESC_W-1:0] mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, push_ptr;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic              addr_err_q, addr_err_d, ovf_q, ovf_d;
    logic [CNT_W-1:0]  done_cnt_q;
    logic [31:0]       rdata_d, rdata_q;
    logic              rvalid_q;

    logic cmd_wr, unmapped_wr, commit, flush, pop, push, empty, full;

    assign empty       = (cnt_q == '0);
    assign full        = (cnt_q == FULL_CNT);
    assign pop         = !empty && cfg_ready;
    assign cmd_wr      = reg_wen && (reg_waddr == CMD_ADDR);
    assign commit      = cmd_wr && reg_wdata[0];
    assign flush       = cmd_wr && reg_wdata[1];
    // STAT is mapped (read-only): writes to it are dropped without an error.
    assign unmapped_wr = reg_wen && (32'(reg_waddr) >= REG_N) &&
                         (reg_waddr != CMD_ADDR) && (reg_waddr != STAT_ADDR);

    // Byte-enabled shadow write decode and flat view of the bank for snapshots.
    always_comb begin
        shadow_flat = '0;
        for (int i = 0; i < REG_N; i++) begin
            shadow_d[i] = shadow_q[i];
            if (reg_wen && (reg_waddr == ADDR_W'(i))) begin
                for (int b = 0; b < 4; b++) begin
                    if (reg_wstrb[b]) shadow_d[i][8*b +: 8] = reg_wdata[8*b +: 8];
                end
            end
            shadow_flat[32*i +: 32] = shadow_q[i];
        end
    end

    // FIFO pointer/count and sticky flag next-state; flush acts before a same-cycle push.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        addr_err_d = addr_err_q;
        ovf_d      = ovf_q;
        push       = 1'b0;
        push_ptr   = wr_ptr_q;
        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            cnt_d      = '0;
            addr_err_d = 1'b0;
            ovf_d      = 1'b0;
            push_ptr   = '0;
            if (commit) begin
                push     = 1'b1;
                wr_ptr_d = PTR_W'(1);
                cnt_d    = (PTR_W + 1)'(1);
            end
        end else begin
            if (commit) begin
                if (!full || pop) push = 1'b1;
                else              ovf_d = 1'b1;
            end
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (push && !pop)      cnt_d = cnt_q + 1'b1;
            else if (!push && pop) cnt_d = cnt_q - 1'b1;
        end
        if (unmapped_wr) addr_err_d = 1'b1;
    end

    // Read mux: shadow words, status, everything else reads as zero.
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < REG_N; i++) begin
            if (reg_raddr == ADDR_W'(i)) rdata_d = shadow_q[i];
        end
        if (reg_raddr == STAT_ADDR) begin
            rdata_d = {16'(done_cnt_q), 8'(cnt_q), 4'b0000, addr_err_q, ovf_q, full, empty};
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) shadow_q[i] <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            addr_err_q <= 1'b0;
            ovf_q      <= 1'b0;
            done_cnt_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            for (int i = 0; i < REG_N; i++) shadow_q[i] <= shadow_d[i];
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            addr_err_q <= addr_err_d;
            ovf_q      <= ovf_d;
            if (task_done) done_cnt_q <= done_cnt_q + 1'b1;
            if (reg_ren)   rdata_q    <= rdata_d;
            rvalid_q   <= reg_ren;
        end
    end

    // Descriptor storage; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[push_ptr] <= shadow_flat;
    end

    assign cfg_valid  = !empty;
    assign cfg_desc   = empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_cnt   = cnt_q;
    assign reg_rdata  = rdata_q;
    assign reg_rvalid = rvalid_q;

endmodule

// File: tb/tb_generic_pool_cfg_task_queue.sv
// Scoreboard bench: stimulus pushes expected reads/descriptors, a negedge monitor checks them.
module tb_generic_pool_cfg_task_queue;

    localparam int REG_N      = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 4;
    localparam int CNT_W      = 4;
    localparam int DESC_W     = REG_N * 32;
    localparam logic [ADDR_W-1:0] CMD  = 4'd10;
    localparam logic [ADDR_W-1:0] STAT = 4'd11;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        reg_wen = 1'b0;
    logic [ADDR_W-1:0]           reg_waddr = '0;
    logic [31:0]                 reg_wdata = '0;
    logic [3:0]                  reg_wstrb = '0;
    logic                        reg_ren = 1'b0;
    logic [ADDR_W-1:0]           reg_raddr = '0;
    logic [31:0]                 reg_rdata;
    logic                        reg_rvalid;
    logic                        cfg_valid;
    logic                        cfg_ready = 1'b0;
    logic [DESC_W-1:0]           cfg_desc;
    logic                        task_done = 1'b0;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

    logic [31:0]       sh [REG_N];
    logic [DESC_W-1:0] exp_desc_q [$];
    logic [31:0]       exp_rd_q [$];
    int n_cmp = 0;
    int n_err = 0;

    generic_pool_cfg_task_queue #(
        .REG_N      (REG_N),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_wen    (reg_wen),
        .reg_waddr  (reg_waddr),
        .reg_wdata  (reg_wdata),
        .reg_wstrb  (reg_wstrb),
        .reg_ren    (reg_ren),
        .reg_raddr  (reg_raddr),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_desc   (cfg_desc),
        .task_done  (task_done),
        .fifo_cnt   (fifo_cnt)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_desc(input logic [DESC_W-1:0] act, input logic [DESC_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL desc: got word0 0x%08h (0x%h) want word0 0x%08h (0x%h)",
                     act[31:0], act, exp[31:0], exp);
        end
    endtask

    function automatic logic [DESC_W-1:0] model_desc();
        logic [DESC_W-1:0] d;
        for (int i = 0; i < REG_N; i++) d[32*i +: 32] = sh[i];
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                      input logic [3:0] strb);
        reg_wen   = 1'b1;
        reg_waddr = addr;
        reg_wdata = data;
        reg_wstrb = strb;
        if (int'(addr) < REG_N) begin
            for (int b = 0; b < 4; b++) if (strb[b]) sh[addr][8*b +: 8] = data[8*b +: 8];
        end
        tick();
        reg_wen = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] addr, input logic [31:0] exp);
        reg_ren   = 1'b1;
        reg_raddr = addr;
        exp_rd_q.push_back(exp);
        tick();
        reg_ren = 1'b0;
    endtask

    // exp_push: whether this commit is expected to land in the FIFO.
    task automatic cmd(input bit do_commit, input bit do_flush, input bit exp_push);
        if (do_flush) exp_desc_q.delete();
        if (exp_push) exp_desc_q.push_back(model_desc());
        wr(CMD, {30'd0, do_flush, do_commit}, 4'hF);
    endtask

    task automatic pop_n(input int n);
        cfg_ready = 1'b1;
        repeat (n) tick();
        cfg_ready = 1'b0;
    endtask

    // Monitor: every read response and every handshake is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (reg_rvalid) begin
                if (exp_rd_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rd_unexpected: got 0x%08h want no read", reg_rdata);
                end else begin
                    logic [31:0] e;
                    e = exp_rd_q.pop_front();
                    check32("rd_data", reg_rdata, e);
                end
            end
            if (cfg_valid && cfg_ready) begin
                if (exp_desc_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL desc_unexpected: got word0 0x%08h want no descriptor",
                             cfg_desc[31:0]);
                end else begin
                    logic [DESC_W-1:0] e;
                    e = exp_desc_q.pop_front();
                    check_desc(cfg_desc, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < REG_N; i++) sh[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check32("rst_cfg_valid", 32'(cfg_valid), 32'd0);
        check32("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
        check32("rst_desc_nonzero", 32'(|cfg_desc), 32'd0);
        check32("rst_rvalid", 32'(reg_rvalid), 32'd0);
        check32("rst_rdata", reg_rdata, 32'd0);
        rst = 1'b0;
        tick();
        rd(STAT, 32'h0000_0001);

        // Fill bank, commit, descriptor visible next cycle
        for (int i = 0; i < REG_N; i++) wr(ADDR_W'(i), 32'h100 + 32'(i), 4'hF);
        cmd(1'b1, 1'b0, 1'b1);
        check32("t1_cfg_valid", 32'(cfg_valid), 32'd1);
        check32("t1_fifo_cnt", 32'(fifo_cnt), 32'd1);
        check32("t1_word3", cfg_desc[127:96], 32'h103);
        rd(STAT, 32'h0000_0100);
        pop_n(1);
        check32("t1_empty_after_pop", 32'(cfg_valid), 32'd0);

        // Byte strobes, rvalid pulse, read-during-write returns old value
        wr(4'd2, 32'h0, 4'hF);
        wr(4'd2, 32'hAABB_CCDD, 4'b0101);
        rd(4'd2, 32'h00BB_00DD);
        check32("t2_rvalid_hi", 32'(reg_rvalid), 32'd1);
        tick();
        check32("t2_rvalid_pulse", 32'(reg_rvalid), 32'd0);
        reg_ren   = 1'b1;
        reg_raddr = 4'd2;
        exp_rd_q.push_back(32'h00BB_00DD);
        wr(4'd2, 32'h1111_1111, 4'hF);
        reg_ren = 1'b0;
        rd(4'd2, 32'h1111_1111);

        // Overflow: 5 commits into a 4-deep FIFO, then drain in order
        for (int k = 1; k <= 5; k++) begin
            wr(4'd0, 32'(k), 4'hF);
            cmd(1'b1, 1'b0, k <= 4);
        end
        check32("t3_fifo_cnt", 32'(fifo_cnt), 32'd4);
        rd(STAT, 32'h0000_0406);
        pop_n(4);
        check32("t3_drained", 32'(cfg_valid), 32'd0);
        check32("t3_cnt_zero", 32'(fifo_cnt), 32'd0);
        cmd(1'b0, 1'b1, 1'b0);
        rd(STAT, 32'h0000_0001);

        // Commit into a full FIFO while popping
        for (int k = 0; k < 4; k++) begin
            wr(4'd0, 32'h10 + 32'(k), 4'hF);
            cmd(1'b1, 1'b0, 1'b1);
        end
        check32("t4_full_cnt", 32'(fifo_cnt), 32'd4);
        wr(4'd0, 32'h14, 4'hF);
        cfg_ready = 1'b1;
        cmd(1'b1, 1'b0, 1'b1);
        cfg_ready = 1'b0;
        check32("t4_cnt_held", 32'(fifo_cnt), 32'd4);
        rd(STAT, 32'h0000_0402);
        pop_n(4);
        check32("t4_drained", 32'(cfg_valid), 32'd0);

        // Sticky errors, unmapped write, then flush+commit
        for (int k = 0; k < 5; k++) begin
            wr(4'd0, 32'h20 + 32'(k), 4'hF);
            cmd(1'b1, 1'b0, k < 4);
        end
        wr(4'd13, 32'hDEAD_BEEF, 4'hF);
        pop_n(1);
        rd(STAT, 32'h0000_030C);
        rd(4'd0, 32'h24);
        rd(4'd9, 32'h109);
        cmd(1'b1, 1'b1, 1'b1);
        check32("t5_cnt_one", 32'(fifo_cnt), 32'd1);
        rd(STAT, 32'h0000_0100);
        pop_n(1);
        check32("t5_drained", 32'(cfg_valid), 32'd0);

        // Done counter wrap (CNT_W = 4) and read-vs-increment ordering
        repeat (17) begin
            task_done = 1'b1;
            tick();
            task_done = 1'b0;
            tick();
        end
        rd(STAT, 32'h0001_0001);
        task_done = 1'b1;
        rd(STAT, 32'h0001_0001);
        task_done = 1'b0;
        rd(STAT, 32'h0002_0001);

        // Asynchronous reset with entries queued
        wr(4'd0, 32'h30, 4'hF);
        cmd(1'b1, 1'b0, 1'b1);
        wr(4'd0, 32'h31, 4'hF);
        cmd(1'b1, 1'b0, 1'b1);
        check32("t7_cnt_two", 32'(fifo_cnt), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check32("t7_async_valid", 32'(cfg_valid), 32'd0);
        check32("t7_async_cnt", 32'(fifo_cnt), 32'd0);
        exp_desc_q.delete();
        for (int i = 0; i < REG_N; i++) sh[i] = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        rd(4'd0, 32'h0);
        rd(STAT, 32'h0000_0001);

        repeat (3) tick();
        check32("rd_scoreboard_drained", 32'(exp_rd_q.size()), 32'd0);
        check32("desc_scoreboard_drained", 32'(exp_desc_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
